// File: rtl/niosqs_jtag_dbg_pkg.sv
// Shared types and constants for the Nios II JTAG debug scan driver.
package niosqs_jtag_dbg_pkg;

  localparam int unsigned IR_W      = 2;
  localparam int unsigned DR_W      = 38;
  localparam int unsigned BIT_CNT_W = 6;

  // Virtual IR encodings understood by the debug module's TCK-side logic.
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr,
    StRsp
  } scan_state_e;

endpackage

// File: rtl/niosqs_jtag_tck_gen.sv
// Half-period counter: registered tck plus phase_start/phase_end pulses while enabled.
module niosqs_jtag_tck_gen #(
  parameter int unsigned TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic phase_start,
  output logic phase_end
);

  localparam int unsigned PhaseLen = 2 * TCK_HALF;

  logic [4:0] cnt_q;
  logic       tck_q;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == 5'(PhaseLen - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tck_q <= 1'b0;
    end else begin
      tck_q <= en && (cnt_q >= 5'(TCK_HALF));
    end
  end

  assign tck         = tck_q;
  assign phase_start = en && (cnt_q == 5'd0);
  assign phase_end   = en && (cnt_q == 5'(PhaseLen - 1));

endmodule

// File: rtl/niosqs_nios2_qsys_0_jtag_debug_scan_driver.sv
// Virtual-JTAG scan initiator: IR update, DR capture/shift/update, captured word returned.
// Optional JTAG_SCAN_IR_CACHE_EN skips the UIR phase when the IR is unchanged since the last scan.
module niosqs_nios2_qsys_0_jtag_debug_scan_driver
  import niosqs_jtag_dbg_pkg::*;
#(
  parameter int unsigned TCK_HALF = 2,
  parameter int unsigned IR_W     = niosqs_jtag_dbg_pkg::IR_W,
  parameter int unsigned DR_W     = niosqs_jtag_dbg_pkg::DR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_data,
  output logic [IR_W-1:0] ir_in,
  output logic            tck,
  output logic            tdi,
  input  logic            tdo,
  output logic            vs_uir,
  output logic            vs_cdr,
  output logic            vs_sdr,
  output logic            vs_udr,
  output logic            jtag_state_rti
);

  scan_state_e          state_q, state_d;
  logic [DR_W-1:0]      sr_q, sr_d, rsp_data_q;
  logic [IR_W-1:0]      ir_lat_q, ir_in_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic                 shift_q;
  logic                 cmd_ready_q, rsp_valid_q, tdi_q, rti_q;
  logic                 vs_uir_q, vs_cdr_q, vs_sdr_q, vs_udr_q;
  logic                 tck_en, phase_start, phase_end;
  logic                 cmd_hs, rsp_hs, skip_uir;

  assign cmd_hs = cmd_valid && cmd_ready_q;
  assign rsp_hs = rsp_valid_q && rsp_ready;
  assign tck_en = (state_q == StUir) || (state_q == StCdr) ||
                  (state_q == StSdr) || (state_q == StUdr);

  niosqs_jtag_tck_gen #(
    .TCK_HALF(TCK_HALF)
  ) u_tck_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (tck_en),
    .tck        (tck),
    .phase_start(phase_start),
    .phase_end  (phase_end)
  );

`ifdef JTAG_SCAN_IR_CACHE_EN
  logic done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else if (rsp_hs) begin
      done_q <= 1'b1;
    end
  end

  assign skip_uir = done_q && (cmd_ir == ir_in_q);
`else
  assign skip_uir = 1'b0;
`endif

  // tdo is taken one edge after phase_end so it is sampled in the last tck-high cycle
  // as seen on the registered pins.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    if (shift_q) begin
      sr_d = {tdo, sr_q[DR_W-1:1]};
    end
    unique case (state_q)
      StIdle: begin
        if (cmd_hs) begin
          sr_d    = cmd_data;
          state_d = skip_uir ? StCdr : StUir;
        end
      end
      StUir: if (phase_end) state_d = StCdr;
      StCdr: if (phase_end) state_d = StSdr;
      StSdr: if (phase_end && (bit_cnt_q == BIT_CNT_W'(DR_W - 1))) state_d = StUdr;
      StUdr: if (phase_end) state_d = StRsp;
      StRsp: if (rsp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      ir_lat_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ir_in_q     <= '0;
      tdi_q       <= 1'b0;
      vs_uir_q    <= 1'b0;
      vs_cdr_q    <= 1'b0;
      vs_sdr_q    <= 1'b0;
      vs_udr_q    <= 1'b0;
      rti_q       <= 1'b1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      shift_q <= (state_q == StSdr) && phase_end;
      if (cmd_hs) begin
        ir_lat_q <= cmd_ir;
      end
      if (state_q != StSdr) begin
        bit_cnt_q <= '0;
      end else if (phase_end && (bit_cnt_q != BIT_CNT_W'(DR_W - 1))) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      // Pins mirror the internal phase one cycle later; cmd_ready tracks state_d
      // so it drops on the accepting edge and rises on the response handshake.
      cmd_ready_q <= (state_d == StIdle);
      rsp_valid_q <= (state_q == StRsp) && !rsp_hs;
      if (state_q == StRsp) begin
        rsp_data_q <= sr_q;
      end
      if ((state_q == StUir) && phase_start) begin
        ir_in_q <= ir_lat_q;
      end
      if ((state_q == StSdr) && phase_start) begin
        tdi_q <= sr_d[0];
      end
      vs_uir_q <= (state_q == StUir);
      vs_cdr_q <= (state_q == StCdr);
      vs_sdr_q <= (state_q == StSdr);
      vs_udr_q <= (state_q == StUdr);
      rti_q    <= (state_q == StIdle) || (state_q == StRsp);
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign ir_in          = ir_in_q;
  assign tdi            = tdi_q;
  assign vs_uir         = vs_uir_q;
  assign vs_cdr         = vs_cdr_q;
  assign vs_sdr         = vs_sdr_q;
  assign vs_udr         = vs_udr_q;
  assign jtag_state_rti = rti_q;

endmodule
